// File: rtl/scalar_wb_queue.sv
// Writeback front end for the scalar register file: arbitrates LSU/ALU results into an
// in-order FIFO, drains one write per cycle, and tracks pending destinations for decode.
module scalar_wb_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lsu_valid,
  input  logic [4:0]                 lsu_rd,
  input  logic [WIDTH-1:0]           lsu_wd,
  output logic                       lsu_ready,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_rd,
  input  logic [WIDTH-1:0]           alu_wd,
  output logic                       alu_ready,
  output logic [4:0]                 RD,
  output logic [WIDTH-1:0]           WD,
  output logic                       WES,
  input  logic                       rsv_valid,
  input  logic [4:0]                 rsv_rd,
  output logic                       rsv_ok,
  input  logic [4:0]                 q_rs1,
  input  logic [4:0]                 q_rs2,
  input  logic [4:0]                 q_rs3,
  output logic                       busy1,
  output logic                       busy2,
  output logic                       busy3,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]       rd_mem [DEPTH];
  logic [WIDTH-1:0] wd_mem [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;

  logic             full;
  logic             push_lsu;
  logic             push_alu;
  logic             push;
  logic             pop;
  logic [4:0]       push_rd;
  logic [WIDTH-1:0] push_wd;

  logic [4:0]       rd_p1;
  logic [WIDTH-1:0] wd_p1;
  logic             vld_p1;

  logic [31:0]      pending;
  logic [31:0]      pending_nxt;

  // Enqueue arbitration: LSU always wins; a same-cycle pop never frees a slot.
  assign full      = (count_q == CW'(DEPTH));
  assign lsu_ready = !full;
  assign alu_ready = !full && !lsu_valid;
  assign push_lsu  = lsu_valid && lsu_ready;
  assign push_alu  = alu_valid && alu_ready;
  assign push      = push_lsu || push_alu;
  assign push_rd   = push_lsu ? lsu_rd : alu_rd;
  assign push_wd   = push_lsu ? lsu_wd : alu_wd;
  assign pop       = (count_q != '0);

  always_comb begin
    count_nxt = count_q;
    if (push && !pop)
      count_nxt = count_q + CW'(1);
    else if (!push && pop)
      count_nxt = count_q - CW'(1);
  end

  // Clear for the register being written this cycle first, so a same-cycle set overrides it.
  always_comb begin
    pending_nxt = pending;
    if (vld_p1)
      pending_nxt[rd_p1] = 1'b0;
    if (rsv_valid && rsv_ok)
      pending_nxt[rsv_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr] <= push_rd;
      wd_mem[wr_ptr] <= push_wd;
    end
  end

  // Stage p1: head of FIFO registered onto the register file write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rd_p1   <= '0;
      wd_p1   <= '0;
      vld_p1  <= 1'b0;
      pending <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        rd_p1  <= rd_mem[rd_ptr];
        wd_p1  <= wd_mem[rd_ptr];
      end
      vld_p1  <= pop;
      count_q <= count_nxt;
      pending <= pending_nxt;
    end
  end

  assign RD     = rd_p1;
  assign WD     = wd_p1;
  assign WES    = vld_p1;
  assign count  = count_q;
  assign rsv_ok = !pending[rsv_rd];
  assign busy1  = pending[q_rs1];
  assign busy2  = pending[q_rs2];
  assign busy3  = pending[q_rs3];

endmodule
